exu_bjp_cmt: RTL and testbench

EXU_BJP_CMT -- requirements
Module: exu_bjp_cmt

---
 rtl/exu_bjp_cmt.sv | 55 +++++
 tb/tb_exu_bjp_cmt.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/exu_bjp_cmt.sv
// exu_bjp_cmt: commits branch/jump results, requests an IFU flush on mispredict and counts branches/mispredicts
module exu_bjp_cmt #(
  parameter int XLEN = 32,
  parameter int PC_SIZE = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmt_i_valid,
  output logic               cmt_i_ready,
  input  logic [PC_SIZE-1:0] cmt_i_pc,
  input  logic               cmt_i_bjp,
  input  logic               cmt_i_prdt,
  input  logic               cmt_i_rslv,
  input  logic [PC_SIZE-1:0] cmt_i_target,
  output logic               flush_o_valid,
  input  logic               flush_o_ready,
  output logic [PC_SIZE-1:0] flush_o_pc,
  output logic [31:0]        perf_bjp_cnt,
  output logic [31:0]        perf_mis_cnt
);
  if (XLEN < PC_SIZE) begin : g_chk
    $error("XLEN must be at least PC_SIZE");
  end
  typedef enum logic {IDLE, FLUSH} state_t;
  state_t state_q, state_d;
  logic [PC_SIZE-1:0] pc_q, pc_d;
  logic [31:0] bjp_q, bjp_d, mis_q, mis_d;
  logic acc, mis;
  assign cmt_i_ready = state_q == IDLE;
  assign flush_o_valid = state_q == FLUSH;
  assign flush_o_pc = pc_q;
  assign perf_bjp_cnt = bjp_q;
  assign perf_mis_cnt = mis_q;
  always_comb begin
    acc = cmt_i_valid & cmt_i_ready;
    mis = cmt_i_bjp & (cmt_i_prdt ^ cmt_i_rslv);
    state_d = state_q == IDLE ? (acc & mis ? FLUSH : IDLE) : (flush_o_ready ? IDLE : FLUSH);
    pc_d = acc & mis ? (cmt_i_rslv ? cmt_i_target : cmt_i_pc + PC_SIZE'(4)) : pc_q;
    bjp_d = bjp_q + 32'(acc & cmt_i_bjp);
    mis_d = mis_q + 32'(acc & mis);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q <= '0;
      bjp_q <= '0;
      mis_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      bjp_q <= bjp_d;
      mis_q <= mis_d;
    end
  end
endmodule

// File: tb/tb_exu_bjp_cmt.sv
// tb_exu_bjp_cmt: directed scoreboard bench for exu_bjp_cmt
module tb_exu_bjp_cmt;
  logic clk = 0, rst = 1;
  logic cmt_i_valid = 0, cmt_i_ready, cmt_i_bjp = 0, cmt_i_prdt = 0, cmt_i_rslv = 0;
  logic [31:0] cmt_i_pc = 0, cmt_i_target = 0, flush_o_pc, perf_bjp_cnt, perf_mis_cnt;
  logic flush_o_valid, flush_o_ready = 0;
  int total = 0, bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] e;
  always #5 clk = ~clk;
  exu_bjp_cmt dut (
    .clk(clk), .rst(rst),
    .cmt_i_valid(cmt_i_valid), .cmt_i_ready(cmt_i_ready), .cmt_i_pc(cmt_i_pc),
    .cmt_i_bjp(cmt_i_bjp), .cmt_i_prdt(cmt_i_prdt), .cmt_i_rslv(cmt_i_rslv),
    .cmt_i_target(cmt_i_target), .flush_o_valid(flush_o_valid), .flush_o_ready(flush_o_ready),
    .flush_o_pc(flush_o_pc), .perf_bjp_cnt(perf_bjp_cnt), .perf_mis_cnt(perf_mis_cnt)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (flush_o_valid && flush_o_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL flush_unexpected got=%h exp=none", flush_o_pc);
      end else begin
        e = exp_q.pop_front();
        chk("flush_pc", flush_o_pc, e);
      end
    end
  end
  task automatic send(input logic [31:0] pc, input logic bjp, input logic prdt, input logic rslv, input logic [31:0] tgt);
    cmt_i_valid = 1;
    cmt_i_pc = pc;
    cmt_i_bjp = bjp;
    cmt_i_prdt = prdt;
    cmt_i_rslv = rslv;
    cmt_i_target = tgt;
    if (bjp && prdt != rslv) exp_q.push_back(rslv ? tgt : pc + 32'd4);
    @(posedge clk) #1;
    cmt_i_valid = 0;
  endtask
  task automatic flush_hs();
    flush_o_ready = 1;
    @(posedge clk) #1;
    flush_o_ready = 0;
  endtask
  task automatic cnt(input string name, input logic [31:0] b, input logic [31:0] m);
    @(negedge clk);
    chk({name, "_bjp"}, perf_bjp_cnt, b);
    chk({name, "_mis"}, perf_mis_cnt, m);
  endtask
  initial begin
    #3;
    chk("rst_ready", 32'(cmt_i_ready), 1);
    chk("rst_valid", 32'(flush_o_valid), 0);
    chk("rst_pc", flush_o_pc, 0);
    chk("rst_bjp", perf_bjp_cnt, 0);
    chk("rst_mis", perf_mis_cnt, 0);
    @(posedge clk) #1;
    rst = 0;
    send(32'h100, 1, 1, 1, 32'h0);
    cnt("correct", 1, 0);
    chk("correct_valid", 32'(flush_o_valid), 0);
    chk("correct_ready", 32'(cmt_i_ready), 1);
    @(posedge clk) #1;
    send(32'h150, 0, 1, 0, 32'h0);
    cnt("nonbjp", 1, 0);
    chk("nonbjp_valid", 32'(flush_o_valid), 0);
    @(posedge clk) #1;
    send(32'h200, 1, 1, 0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("nt_valid", 32'(flush_o_valid), 1);
      chk("nt_pc", flush_o_pc, 32'h204);
      chk("nt_ready", 32'(cmt_i_ready), 0);
      @(posedge clk) #1;
    end
    flush_hs();
    @(negedge clk);
    chk("nt_idle_valid", 32'(flush_o_valid), 0);
    chk("nt_idle_ready", 32'(cmt_i_ready), 1);
    chk("nt_mis", perf_mis_cnt, 1);
    @(posedge clk) #1;
    send(32'h300, 1, 0, 1, 32'h8000_0040);
    @(negedge clk);
    chk("tk_pc", flush_o_pc, 32'h8000_0040);
    chk("tk_mis", perf_mis_cnt, 2);
    @(posedge clk) #1;
    flush_hs();
    send(32'h400, 1, 0, 1, 32'h1000);
    cmt_i_valid = 1;
    cmt_i_pc = 32'h500;
    cmt_i_bjp = 1;
    cmt_i_prdt = 0;
    cmt_i_rslv = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("b2b_ready", 32'(cmt_i_ready), 0);
      chk("b2b_bjp_hold", perf_bjp_cnt, 4);
      @(posedge clk) #1;
    end
    flush_hs();
    cnt("b2b_hs", 4, 3);
    chk("b2b_ready_back", 32'(cmt_i_ready), 1);
    @(posedge clk) #1;
    cmt_i_valid = 0;
    cnt("b2b_after", 5, 3);
    chk("b2b_valid", 32'(flush_o_valid), 0);
    @(posedge clk) #1;
    send(32'hFFFF_FFFC, 1, 1, 0, 32'h0);
    @(negedge clk);
    chk("wrap_pc", flush_o_pc, 32'h0);
    @(posedge clk) #1;
    flush_hs();
    force dut.mis_q = 32'hFFFF_FFFF;
    #1 release dut.mis_q;
    cnt("pre_wrap", 6, 32'hFFFF_FFFF);
    @(posedge clk) #1;
    send(32'h600, 1, 1, 0, 32'h0);
    cnt("cnt_wrap", 7, 0);
    chk("mid_valid", 32'(flush_o_valid), 1);
    #2 rst = 1;
    #1;
    chk("async_valid", 32'(flush_o_valid), 0);
    chk("async_ready", 32'(cmt_i_ready), 1);
    chk("async_pc", flush_o_pc, 0);
    chk("async_bjp", perf_bjp_cnt, 0);
    chk("async_mis", perf_mis_cnt, 0);
    void'(exp_q.pop_back());
    @(posedge clk) #1;
    rst = 0;
    send(32'h700, 1, 1, 1, 32'h0);
    cnt("post_rst", 1, 0);
    chk("post_rst_valid", 32'(flush_o_valid), 0);
    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
